// File: rtl/irq_pend_ctrl.sv
// rtl/irq_pend_ctrl.sv - interrupt pending capture and irq/ack/eoi dispatch around an 8-input priority encoder
//
// Latches rising edges of req_i into a pending register and exposes the
// masked pending vector to an external priority encoder. The encoder's code
// comes back on enc_code_i. One vector at a time is presented to the CPU
// through an irq/ack/eoi handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   req_i       request levels (already synchronised)
//   mask_i      per-source dispatch enable
//   pend_o      pending & mask_i, drives the encoder input
//   enc_code_i  encoder result {valid, index}
//   irq_o       interrupt request to the CPU
//   vec_o       latched vector index
//   ack_i       CPU acknowledge pulse
//   eoi_i       CPU end-of-interrupt pulse
//   busy_o      vector is being serviced
//   err_o       sticky inconsistent-encoder-code flag
//   ovf_o       sticky coalesced-request flags     (IRQ_PEND_OVF_EN only)
//   ovf_clr_i   clears ovf_o                       (IRQ_PEND_OVF_EN only)
//
// Optional feature macro: IRQ_PEND_OVF_EN

module irq_pend_ctrl #(
   parameter int NSRC = 8,
   parameter int VW   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] req_i,
   input  logic [NSRC-1:0] mask_i,
   output logic [NSRC-1:0] pend_o,
   input  logic [VW:0]     enc_code_i,
   output logic            irq_o,
   output logic [VW-1:0]   vec_o,
   input  logic            ack_i,
   input  logic            eoi_i,
   output logic            busy_o,
`ifdef IRQ_PEND_OVF_EN
   output logic [NSRC-1:0] ovf_o,
   input  logic            ovf_clr_i,
`endif
   output logic            err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [NSRC-1:0]   req_q;
   logic [NSRC-1:0]   pending, pending_n;
   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   clr;
   logic              irq_q, irq_n;
   logic [VW-1:0]     vec_q, vec_n;
   logic              busy_q, busy_n;
   logic              err_q, err_n;

   assign rise   = req_i & ~req_q;
   assign pend_o = pending & mask_i;

   assign irq_o  = irq_q;
   assign vec_o  = vec_q;
   assign busy_o = busy_q;
   assign err_o  = err_q;

   always_comb begin
      state_n = state;
      irq_n   = irq_q;
      vec_n   = vec_q;
      busy_n  = busy_q;
      err_n   = err_q;
      clr     = '0;
      unique case (state)
         IDLE: begin
            if (enc_code_i[VW]) begin
               // The encoder should only report an index that is actually
               // pending and enabled; anything else is flagged, not served.
               if (pend_o[enc_code_i[VW-1:0]]) begin
                  vec_n   = enc_code_i[VW-1:0];
                  irq_n   = 1'b1;
                  state_n = ISSUE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (ack_i) begin
               clr[vec_q] = 1'b1;
               irq_n      = 1'b0;
               busy_n     = 1'b1;
               state_n    = SERVICE;
            end
         end
         SERVICE: begin
            if (eoi_i) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            irq_n   = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
      // A new edge on the bit being acknowledged is applied after the clear,
      // so a fresh request in the ack cycle is never dropped.
      pending_n = (pending & ~clr) | rise;
   end

`ifdef IRQ_PEND_OVF_EN
   logic [NSRC-1:0] ovf_q;
   logic [NSRC-1:0] ovf_n;

   assign ovf_o = ovf_q;

   // Coalesced request: an edge arriving while the same bit is still pending.
   always_comb begin
      ovf_n = (ovf_q & ~{NSRC{ovf_clr_i}}) | (rise & pending);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= '0;
      else        ovf_q <= ovf_n;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         req_q   <= '0;
         pending <= '0;
         irq_q   <= 1'b0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         req_q   <= req_i;
         pending <= pending_n;
         irq_q   <= irq_n;
         vec_q   <= vec_n;
         busy_q  <= busy_n;
         err_q   <= err_n;
      end
   end

endmodule

// File: doc/irq_pend_ctrl.md
Name: irq_pend_ctrl

Overview:
- Interrupt pending/dispatch controller wrapped around the 8-input priority encoder.
- Captures rising edges on 8 request lines into a pending register and drives the masked pending vector to the encoder's input.
- Takes the encoder's 4-bit code back and presents one vector at a time to the CPU through an irq/ack/eoi handshake.
- Clears the serviced pending bit on ack.

Parameters:
- NSRC, 8, number of request sources. Fixed at 8 to match the encoder width; any other value is unsupported.
- VW, 3, vector index width.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- req_i  input  8  asynchronous-origin request levels, already synchronised upstream
- mask_i  input  8  per-source enable; 1 = source may be dispatched
- pend_o  output  8  pending & mask_i; feeds the priority encoder input
- enc_code_i  input  4  encoder result: bit3 = valid, bits2:0 = index of lowest set pending bit; 4'b0000 = none
- irq_o  output  1  interrupt request to CPU
- vec_o  output  3  latched vector index; stable while irq_o or busy_o is high
- ack_i  input  1  CPU acknowledge, single-cycle pulse
- eoi_i  input  1  CPU end-of-interrupt, single-cycle pulse
- busy_o  output  1  high in SERVICE state
- err_o  output  1  sticky; set on an inconsistent encoder code; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state: req_q=0, pending=0, state=IDLE, irq_o=0, vec_o=0, busy_o=0, err_o=0.
  - Reset mid-handshake abandons the handshake with no pending bit retained.
- Edge detect: req_q <= req_i each cycle; edge = req_i & ~req_q.
  - pending[i] sets on the edge where edge[i]=1. Latency: req_i high at edge n gives pending[i]=1 after edge n.
- pend_o = pending & mask_i, combinational.
  - enc_code_i is combinational from pend_o, so it is valid in the same cycle.
  - Masked bits stay pending and are not lost.
- FSM states: IDLE, ISSUE, SERVICE.
  - IDLE: if enc_code_i[3]=1 and pend_o[enc_code_i[2:0]]=1, then vec_o <= enc_code_i[2:0], irq_o <= 1, go to ISSUE.
  - IDLE, inconsistent code: if enc_code_i[3]=1 but the indexed pend_o bit is 0, set err_o=1 and stay in IDLE.
  - IDLE, no request: enc_code_i[3]=0 means stay in IDLE.
  - ISSUE: irq_o held at 1, vec_o frozen.
    - No preemption: a higher-priority arrival or a mask change does not alter vec_o.
    - On ack_i=1: pending[vec_o] cleared, irq_o <= 0, busy_o <= 1, go to SERVICE.
    - eoi_i is ignored in ISSUE.
  - SERVICE: on eoi_i=1, busy_o <= 0 and go to IDLE. The next dispatch can issue on the following cycle.
    - ack_i is ignored in SERVICE.
    - New edges keep setting pending bits, including the bit in service.
- Simultaneous set and clear of the same bit in one cycle (edge[vec_o] with ack_i): set wins and the bit stays pending. The new request is never lost.
- Back-to-back ack and eoi are allowed on consecutive cycles.
  - Minimum dispatch period is 3 cycles: IDLE to ISSUE, ack, eoi.
- All pending bits set with mask_i=0: no irq is issued and pend_o=0.

Optional Feature:
- Macro: IRQ_PEND_OVF_EN.
- Defined:
  - Adds output ovf_o[7:0] and input ovf_clr_i (1 bit).
  - ovf_o[i] sets sticky when edge[i]=1 while pending[i] is already 1 (a coalesced request).
  - ovf_clr_i=1 clears all ovf_o bits; a set in the same cycle wins.
  - ovf_o resets to 0.
- Not defined: the ports are absent and no overflow logic is generated. Coalesced requests are silently merged.

Test Plan:
- Reset, then req_i=8'h00, mask_i=8'hFF for 10 cycles -> pend_o=0, irq_o=0, busy_o=0, err_o=0 throughout.
- req_i 0->8'h24 in one cycle, mask_i=8'hFF, reference encoder attached -> pend_o=8'h24, irq_o=1 with vec_o=2. Ack -> pend_o=8'h20. Eoi -> next irq with vec_o=5. Ack+eoi -> pend_o=0, irq_o stays 0.
- pending=8'h01 with mask_i=8'hFE -> no irq. Set mask_i=8'hFF -> irq_o=1, vec_o=0 one cycle later.
- In ISSUE with vec_o=3, pulse a new edge on req_i[3] in the same cycle as ack_i -> pending[3] remains 1. After eoi, irq re-issues with vec_o=3.
- Drive enc_code_i=4'b1110 (index 6) while pend_o=8'h01 -> err_o=1 sticky, state stays IDLE, irq_o=0.
- With IRQ_PEND_OVF_EN: two rising edges on req_i[7] with no ack between -> ovf_o=8'h80. Pulse ovf_clr_i -> ovf_o=0. Assert rst_n=0 while in SERVICE -> all outputs 0 on the next edge.
